// File: rtl/cache_line_alloc.sv
// Line-allocation stage for the cache directory: tracks per-line valid bits,
// picks the fill line on each miss (lowest free, else round-robin victim) and runs a sequential flush.
module cache_line_alloc #(
    parameter int ADDR_W = 5,
    parameter int LINES  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    output logic              alloc_ready,
    output logic              alloc_valid,
    output logic [ADDR_W-1:0] alloc_idx,
    output logic              alloc_evict,
    input  logic              inval_en,
    input  logic [ADDR_W-1:0] inval_idx,
    input  logic              flush_start,
    output logic              flush_busy,
    output logic              flush_done,
    output logic [LINES-1:0]  valid_vec,
    output logic              full
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(LINES - 1);
    localparam logic [ADDR_W-1:0] PREV_LINE = ADDR_W'(LINES - 2);

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0] alloc_idx_q, alloc_idx_d;
    logic              alloc_valid_q, alloc_valid_d;
    logic              alloc_evict_q, alloc_evict_d;
    logic              flush_done_q, flush_done_d;

    logic              accept;
    logic [ADDR_W-1:0] sel_idx;
    logic              sel_evict;

    function automatic logic [ADDR_W-1:0] lowest_free(input logic [LINES-1:0] v);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (!v[i]) begin
                idx = ADDR_W'(i);
            end
        end
        return idx;
    endfunction

    assign full        = &valid_q;
    assign alloc_ready = (state_q == IDLE);
    assign flush_busy  = (state_q == FLUSH);
    assign accept      = alloc_req && alloc_ready && !flush_start;

    // Selection always looks at the pre-edge valid bits.
    assign sel_evict = full;
    assign sel_idx   = full ? rr_ptr_q : lowest_free(valid_q);

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        rr_ptr_d      = rr_ptr_q;
        flush_cnt_d   = flush_cnt_q;
        alloc_idx_d   = alloc_idx_q;
        alloc_evict_d = alloc_evict_q;
        alloc_valid_d = 1'b0;
        flush_done_d  = 1'b0;

        if (inval_en) begin
            valid_d[inval_idx] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (flush_start) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                valid_d[flush_cnt_q] = 1'b0;
                flush_cnt_d          = flush_cnt_q + ADDR_W'(1);
                // Registered so the pulse lands in the final flush cycle.
                if (flush_cnt_q == PREV_LINE) begin
                    flush_done_d = 1'b1;
                end
                if (flush_cnt_q == LAST_LINE) begin
                    state_d  = IDLE;
                    rr_ptr_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Applied last so a same-cycle invalidate of the chosen line loses.
        if (accept) begin
            alloc_valid_d    = 1'b1;
            alloc_idx_d      = sel_idx;
            alloc_evict_d    = sel_evict;
            valid_d[sel_idx] = 1'b1;
            if (sel_evict) begin
                rr_ptr_d = rr_ptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            rr_ptr_q      <= '0;
            flush_cnt_q   <= '0;
            alloc_idx_q   <= '0;
            alloc_valid_q <= 1'b0;
            alloc_evict_q <= 1'b0;
            flush_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            rr_ptr_q      <= rr_ptr_d;
            flush_cnt_q   <= flush_cnt_d;
            alloc_idx_q   <= alloc_idx_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_evict_q <= alloc_evict_d;
            flush_done_q  <= flush_done_d;
        end
    end

    assign valid_vec   = valid_q;
    assign alloc_valid = alloc_valid_q;
    assign alloc_idx   = alloc_idx_q;
    assign alloc_evict = alloc_evict_q;
    assign flush_done  = flush_done_q;

endmodule

// File: doc/cache_line_alloc.md
Name: cache_line_alloc

Overview:
Line-allocation stage for the 32-line cache directory. It tracks per-line valid bits and selects the line index to fill on each miss: the lowest-index invalid line, or a round-robin victim when all lines are valid. It also supports single-line invalidation and a sequential flush. The registered alloc_idx output feeds the 5-to-32 one-hot decoder that produces the per-line write enables.

Parameters:
ADDR_W, 5, line index width; fixed to match the downstream 5-to-32 decoder.
LINES, 32, number of lines; must equal 2**ADDR_W.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
alloc_req  input  1  request a line for a fill
alloc_ready  output  1  high when an alloc request can be accepted (state IDLE)
alloc_valid  output  1  one-cycle pulse: alloc_idx/alloc_evict hold a result
alloc_idx  output  ADDR_W  selected line index, registered
alloc_evict  output  1  selected line was valid, so this fill is an eviction
inval_en  input  1  invalidate the single line at inval_idx
inval_idx  input  ADDR_W  line index to invalidate
flush_start  input  1  start a full flush
flush_busy  output  1  high while state FLUSH
flush_done  output  1  one-cycle pulse on the final flush cycle
valid_vec  output  LINES  current valid bits, registered
full  output  1  combinational: all bits of valid_vec are set

Behaviour:
- Reset (rst_n low at a clk edge) clears valid_vec, rr_ptr, flush_cnt, alloc_valid, alloc_idx, alloc_evict and flush_done, and sets state to IDLE. alloc_ready is 1 from the first cycle after reset; flush_busy is 0.
- FSM has two states, IDLE and FLUSH.
  - IDLE -> FLUSH on flush_start.
  - FLUSH -> IDLE after the flush_cnt==31 cycle.
- alloc_ready = (state==IDLE). flush_busy = (state==FLUSH).
- Accept condition: alloc_req && alloc_ready && !flush_start. When flush_start and alloc_req arrive together, the flush wins and the alloc is not accepted; the requester must re-request.
- Line selection uses the valid_vec value before the clock edge.
  - If !full: sel = lowest index with valid_vec[i]==0, evict = 0.
  - If full: sel = rr_ptr, evict = 1.
- Accepted alloc, updated at the next edge (latency 1):
  - alloc_valid=1, alloc_idx=sel, alloc_evict=evict, valid_vec[sel]=1.
  - On an evicting alloc only, rr_ptr increments mod 32 (31 wraps to 0).
- alloc_valid is 0 in every cycle without an accepted alloc. alloc_idx and alloc_evict hold their last values.
- Back-to-back allocs, one per cycle, are supported. Each selection sees the valid bit set by the previous alloc.
- Invalidate: inval_en clears valid_vec[inval_idx] at the next edge. It is honoured in both IDLE and FLUSH.
- Invalidate and accepted alloc in the same cycle:
  - Selection still uses the pre-edge valid_vec.
  - If inval_idx==sel, the set wins and the line ends valid.
  - Otherwise both updates apply.
- Flush:
  - On entry, flush_cnt=0.
  - Each FLUSH cycle clears valid_vec[flush_cnt] and increments flush_cnt.
  - The flush takes exactly 32 cycles in FLUSH. flush_done pulses during the flush_cnt==31 cycle, then the FSM returns to IDLE.
  - rr_ptr is reset to 0 at flush completion.
  - flush_start during FLUSH is ignored.
  - alloc_req during FLUSH is not accepted and does not queue.
- full is combinational on valid_vec, so it reflects register state only, not same-cycle requests.
- rst_n low mid-flush aborts the flush: state IDLE, all registers at their reset values.

Test Plan:
- Reset, then 32 consecutive cycles of alloc_req=1 -> alloc_idx=0,1,...,31 on consecutive cycles, each with alloc_valid=1 and alloc_evict=0. Afterwards full=1 and valid_vec=32'hFFFF_FFFF.
- From full, 34 further allocs -> alloc_idx=0..31,0,1, all with alloc_evict=1. rr_ptr wraps 31->0.
- From full, pulse inval_en with inval_idx=17, then one alloc -> alloc_idx=17, alloc_evict=0, and valid_vec returns to all ones.
- Same cycle as an alloc choosing index 3 (lines 0-2 valid), inval_en with inval_idx=3 -> valid_vec[3]=1. Repeat with inval_idx=1 -> valid_vec[1]=0 and valid_vec[3]=1.
- From full, flush_start together with alloc_req:
  - alloc is not accepted and flush_busy=1 for 32 cycles.
  - alloc_ready=0 throughout; alloc_req held high produces no alloc_valid.
  - flush_done pulses on the 32nd cycle, then valid_vec=0.
  - The next alloc gives alloc_idx=0.
- rst_n low at flush cycle 10 -> next cycle state IDLE, valid_vec=0, flush_busy=0, alloc_ready=1, and no flush_done pulse.
